// File: rtl/lc3_stage_sequencer.sv
// LC-3 stage sequencer: drives STAGE/STALL for FETCH-DECODE-EXECUTE-WRITEBACK, memory waits, skip, TRAP x25 halt.
// Latency: one cycle per stage; memory stages last until MEM_ACK, or until MEM_WAIT_MAX wait cycles elapse.
// Backpressure: a missing MEM_ACK holds the stage with STALL=1; optional counters via LC3_SEQ_PERF_CNT_EN.
module lc3_stage_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    input  logic [15:0] IR,
    input  logic        MEM_ACK,
    input  logic        NEXT_STAGE_LE,
    input  logic [1:0]  NEXT_STAGE,
    output logic [1:0]  STAGE,
    output logic        STALL,
    output logic        MEM_REQ,
    output logic        MEM_RD,
    output logic        INSTR_RETIRED,
    output logic        HALTED,
    output logic        MEM_ERR,
    output logic [31:0] CYCLE_CNT,
    output logic [31:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [3:0]            opcode;
    logic                  mem_op;
    logic                  halt_trap;
    logic                  waiting;
    logic                  timeout;
    logic                  skip;
    logic                  unused_ir;

    assign opcode    = IR[15:12];
    assign mem_op    = (opcode == 4'b0110) || (opcode == 4'b0111);
    assign halt_trap = (opcode == 4'b1111) && (IR[7:0] == 8'h25);
    assign unused_ir = ^IR[11:8];

    assign waiting = MEM_REQ && !MEM_ACK;
    // The last permitted wait cycle is the timeout cycle; an ack there still wins.
    assign timeout = waiting && (wait_cnt == WAIT_CNT_W'(MEM_WAIT_MAX - 1));
    assign skip    = NEXT_STAGE_LE && !STALL &&
                     ((state == S_DECODE) || (state == S_EXECUTE) || (state == S_WRITEBACK));

    function automatic state_t stage_to_state(input logic [1:0] s);
        case (s)
            2'b00:   stage_to_state = S_DECODE;
            2'b01:   stage_to_state = S_EXECUTE;
            2'b10:   stage_to_state = S_WRITEBACK;
            default: stage_to_state = S_FETCH;
        endcase
    endfunction

    // MEM_REQ/MEM_RD depend only on state and IR; STALL alone sees MEM_ACK.
    always_comb begin
        STAGE   = 2'b11;
        STALL   = 1'b1;
        MEM_REQ = 1'b0;
        MEM_RD  = 1'b1;
        case (state)
            S_FETCH: begin
                MEM_REQ = 1'b1;
                STALL   = !MEM_ACK;
            end
            S_DECODE: begin
                STAGE = 2'b00;
                STALL = 1'b0;
            end
            S_EXECUTE: begin
                STAGE = 2'b01;
                STALL = 1'b0;
            end
            S_WRITEBACK: begin
                STAGE = 2'b10;
                if (mem_op) begin
                    MEM_REQ = 1'b1;
                    MEM_RD  = (opcode == 4'b0110);
                    STALL   = !MEM_ACK;
                end else begin
                    STALL = 1'b0;
                end
            end
            default: begin
                STAGE = 2'b11;
                STALL = 1'b1;
            end
        endcase
    end

    assign INSTR_RETIRED = (state == S_WRITEBACK) && !STALL;
    assign HALTED        = (state == S_HALTED);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_HALTED: if (RUN) next_state = S_FETCH;
            S_FETCH: begin
                if (MEM_ACK)      next_state = S_DECODE;
                else if (timeout) next_state = S_HALTED;
            end
            S_DECODE:  next_state = S_EXECUTE;
            S_EXECUTE: next_state = S_WRITEBACK;
            S_WRITEBACK: begin
                if (!STALL)       next_state = halt_trap ? S_HALTED : S_FETCH;
                else if (timeout) next_state = S_HALTED;
            end
            default: next_state = S_IDLE;
        endcase
        if (skip) next_state = stage_to_state(NEXT_STAGE);
    end

    // Counter clears on every non-waiting cycle, so each memory stage starts from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            MEM_ERR  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= waiting ? wait_cnt + WAIT_CNT_W'(1) : '0;
            if (timeout) MEM_ERR <= 1'b1;
        end
    end

`ifdef LC3_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CYCLE_CNT <= '0;
            INSTR_CNT <= '0;
        end else begin
            if ((state != S_IDLE) && (state != S_HALTED)) CYCLE_CNT <= CYCLE_CNT + 32'd1;
            if (INSTR_RETIRED) INSTR_CNT <= INSTR_CNT + 32'd1;
        end
    end
`else
    assign CYCLE_CNT = '0;
    assign INSTR_CNT = '0;
`endif

endmodule
